wi_conditioner: RTL

Input conditioning stage placed directly upstream of the consecutive-ones detector FSM. Takes a raw, asynchronous single-bit input and synchronizes it into `clk` with a two-flop synchronizer. It then debounces the synchronized level with a counter-based state machine and drives the clean level on `wo`, which connects straight to the detector's `wi`. It also provides one-cycle edge pulses and a saturating count of rejected glitches for debug visibility.

---
 rtl/wi_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wi_conditioner.sv
// Input conditioner for the consecutive-ones detector: two-flop synchronizer,
// counter-based debounce FSM, edge pulses and a saturating glitch counter.
module wi_conditioner #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    input  logic       glitch_clr,
    output logic       wo,
    output logic       rise_p,
    output logic       fall_p,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned        GW       = 8;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [GW-1:0]      GL_MAX   = '1;

    typedef enum logic [1:0] {
        ST_LO     = 2'b00,
        ST_CHK_HI = 2'b01,
        ST_HI     = 2'b10,
        ST_CHK_LO = 2'b11
    } state_e;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            s_in;
    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            wo_q, wo_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic [GW-1:0]   glitch_cnt_q, glitch_cnt_d;
    logic            glitch_c;

    // Only sync1 may go metastable; sync2 feeds the FSM.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s_in = sync2_q;

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LO;
            cnt_q        <= '0;
            wo_q         <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wo_q         <= wo_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    // Next state: the sample that leaves a stable state counts as the first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LO: begin
                if (s_in) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CHK_HI: begin
                if (!s_in) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (!s_in) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CHK_LO: begin
                if (s_in) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the transition being taken this edge.
    always_comb begin
        wo_d         = (state_d == ST_HI) || (state_d == ST_CHK_LO);
        rise_d       = (state_q == ST_CHK_HI) && (state_d == ST_HI);
        fall_d       = (state_q == ST_CHK_LO) && (state_d == ST_LO);
        glitch_c     = ((state_q == ST_CHK_HI) && (state_d == ST_LO)) ||
                       ((state_q == ST_CHK_LO) && (state_d == ST_HI));
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_c && (glitch_cnt_q != GL_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + GW'(1);
        end
    end

    assign wo         = wo_q;
    assign rise_p     = rise_q;
    assign fall_p     = fall_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule
